// File: rtl/frame_pkg.sv
// frame_pkg: constants, state encoding and frame-length helper shared by
// param_frame_decoder and its bench.
// Optional feature macro: FRAME_DECODER_CHECKSUM_EN (adds S_CHK / CHK byte).
package frame_pkg;

  localparam logic [7:0] STX1 = 8'hFF;
  localparam logic [7:0] STX2 = 8'h5A;

  // Byte index inside a section; sections hold at most 16 bytes.
  localparam int unsigned IDX_W = $clog2(16) + 1;

  localparam logic [2:0] ENC_WF_STX1 = 3'd0;
  localparam logic [2:0] ENC_WF_STX2 = 3'd1;
  localparam logic [2:0] ENC_CH      = 3'd2;
  localparam logic [2:0] ENC_OFF     = 3'd3;
  localparam logic [2:0] ENC_RSV     = 3'd4;
`ifdef FRAME_DECODER_CHECKSUM_EN
  localparam logic [2:0] ENC_CHK     = 3'd5;
  localparam bit         CHK_EN      = 1'b1;
`else
  localparam bit         CHK_EN      = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_WF_STX1 = ENC_WF_STX1,
    S_WF_STX2 = ENC_WF_STX2,
    S_CH      = ENC_CH,
    S_OFF     = ENC_OFF,
    S_RSV     = ENC_RSV
`ifdef FRAME_DECODER_CHECKSUM_EN
    ,
    S_CHK     = ENC_CHK
`endif
  } state_e;

  // Total bytes on the wire for one frame, both STX bytes included.
  function automatic int unsigned frame_len(input int unsigned n_ch,
                                            input int unsigned n_off,
                                            input int unsigned n_rsv);
    return 2 + n_ch + n_off + n_rsv + (CHK_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// frame_gap_timer: inter-byte gap watchdog. Reloads on clear, counts down
// while enabled, flags expiry once TIMEOUT_CYC idle cycles have been seen.
module frame_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Down-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Reload on clear, otherwise count down and hold at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                      cnt_d = LOAD;
    else if (enable && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // The idle cycle that finds the counter at zero is the TIMEOUT_CYC-th one.
  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/param_frame_decoder.sv
// param_frame_decoder: byte-stream frame parser.
// Frame: FF 5A CH[NUM_CH] OFF[NUM_OFF] RSV[NUM_RSV] (+CHK when
// FRAME_DECODER_CHECKSUM_EN is defined). Good frames update the outputs
// atomically, one cycle after their last byte.
//
// state      | meaning
// S_WF_STX1  | idle, hunting for 8'hFF
// S_WF_STX2  | FF seen, expecting 8'h5A (further FF bytes keep waiting)
// S_CH       | capturing channel bytes
// S_OFF      | capturing offset bytes (skipped when NUM_OFF = 0)
// S_RSV      | discarding reserved bytes (skipped when NUM_RSV = 0)
// S_CHK      | comparing checksum byte (checksum build only)
module param_frame_decoder
  import frame_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NUM_OFF     = 4,
  parameter int unsigned NUM_RSV     = 6,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         sink_data_valid,
  input  logic [7:0]                                   sink_data,
  output logic                                         source_data_valid,
  output logic [NUM_CH*8-1:0]                          source_ch_data,
  output logic [((NUM_OFF == 0) ? 1 : NUM_OFF)*8-1:0]  source_off_data,
  output logic                                         source_frame_err,
  output logic [15:0]                                  source_frame_cnt,
  output logic [2:0]                                   state
);

  localparam int unsigned      OFF_BYTES = (NUM_OFF == 0) ? 1 : NUM_OFF;
  localparam int unsigned      CH_W      = NUM_CH * 8;
  localparam int unsigned      OFF_W     = OFF_BYTES * 8;
  localparam logic [IDX_W-1:0] CH_LAST   = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] OFF_LAST  = IDX_W'(OFF_BYTES - 1);
  localparam logic [IDX_W-1:0] RSV_LAST  = IDX_W'((NUM_RSV == 0) ? 0 : NUM_RSV - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CH_W-1:0]    ch_sh_q, ch_sh_d;
  logic [OFF_W-1:0]   off_sh_q, off_sh_d;
  logic [CH_W-1:0]    ch_out_q, ch_out_d;
  logic [OFF_W-1:0]   off_out_q, off_out_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;
`ifdef FRAME_DECODER_CHECKSUM_EN
  logic [7:0]         xor_q, xor_d;
`endif

  logic               state_legal;
  logic               gap_clear;
  logic               gap_enable;
  logic               gap_expired;
  logic               end_payload;
  logic               commit;
  logic               abort;

  // Flag encodings outside the state set so the FSM and timer can recover.
  always_comb begin
    state_legal = 1'b0;
    case (state_q)
      S_WF_STX1, S_WF_STX2, S_CH, S_OFF, S_RSV: state_legal = 1'b1;
`ifdef FRAME_DECODER_CHECKSUM_EN
      S_CHK:                                    state_legal = 1'b1;
`endif
      default:                                  state_legal = 1'b0;
    endcase
  end

  // Gap timer only runs inside a frame; any accepted byte restarts it.
  assign gap_clear  = sink_data_valid || (state_q == S_WF_STX1) || !state_legal;
  assign gap_enable = (state_q != S_WF_STX1);

  frame_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (gap_clear),
    .enable  (gap_enable),
    .expired (gap_expired)
  );

  // State, shadow and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_WF_STX1;
      idx_q     <= '0;
      ch_sh_q   <= '0;
      off_sh_q  <= '0;
      ch_out_q  <= '0;
      off_out_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ch_sh_q   <= ch_sh_d;
      off_sh_q  <= off_sh_d;
      ch_out_q  <= ch_out_d;
      off_out_q <= off_out_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state, byte capture and commit/abort decisions.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ch_sh_d     = ch_sh_q;
    off_sh_d    = off_sh_q;
    ch_out_d    = ch_out_q;
    off_out_d   = off_out_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    end_payload = 1'b0;
    commit      = 1'b0;
    abort       = 1'b0;

    case (state_q)
      S_WF_STX1: begin
        idx_d = '0;
        if (sink_data_valid && (sink_data == STX1)) state_d = S_WF_STX2;
      end

      S_WF_STX2: begin
        if (sink_data_valid) begin
          if (sink_data == STX2) begin
            state_d = S_CH;
            idx_d   = '0;
          end else if (sink_data != STX1) begin
            state_d = S_WF_STX1;
          end
        end else if (gap_expired) begin
          abort = 1'b1;
        end
      end

      S_CH: begin
        if (sink_data_valid) begin
          for (int i = 0; i < int'(NUM_CH); i++) begin
            if (idx_q == IDX_W'(i)) ch_sh_d[i*8 +: 8] = sink_data;
          end
          if (idx_q == CH_LAST) begin
            idx_d = '0;
            if (NUM_OFF != 0)      state_d = S_OFF;
            else if (NUM_RSV != 0) state_d = S_RSV;
            else                   end_payload = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (gap_expired) begin
          abort = 1'b1;
        end
      end

      S_OFF: begin
        if (sink_data_valid) begin
          for (int i = 0; i < int'(OFF_BYTES); i++) begin
            if (idx_q == IDX_W'(i)) off_sh_d[i*8 +: 8] = sink_data;
          end
          if (idx_q == OFF_LAST) begin
            idx_d = '0;
            if (NUM_RSV != 0) state_d = S_RSV;
            else              end_payload = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (gap_expired) begin
          abort = 1'b1;
        end
      end

      S_RSV: begin
        if (sink_data_valid) begin
          if (idx_q == RSV_LAST) begin
            idx_d       = '0;
            end_payload = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (gap_expired) begin
          abort = 1'b1;
        end
      end

`ifdef FRAME_DECODER_CHECKSUM_EN
      S_CHK: begin
        if (sink_data_valid) begin
          state_d = S_WF_STX1;
          if (sink_data == xor_q) commit = 1'b1;
          else                    err_d  = 1'b1;
        end else if (gap_expired) begin
          abort = 1'b1;
        end
      end
`endif

      default: begin
        state_d  = S_WF_STX1;
        idx_d    = '0;
        ch_sh_d  = '0;
        off_sh_d = '0;
      end
    endcase

    if (end_payload) begin
`ifdef FRAME_DECODER_CHECKSUM_EN
      state_d = S_CHK;
`else
      state_d = S_WF_STX1;
      commit  = 1'b1;
`endif
    end

    if (abort) begin
      state_d = S_WF_STX1;
      idx_d   = '0;
      err_d   = 1'b1;
    end

    // Shadow next-values already hold the final byte, so outputs switch as one.
    if (commit) begin
      ch_out_d  = ch_sh_d;
      off_out_d = off_sh_d;
      valid_d   = 1'b1;
      cnt_d     = cnt_q + 16'd1;
    end
  end

`ifdef FRAME_DECODER_CHECKSUM_EN
  // Checksum accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) xor_q <= '0;
    else       xor_q <= xor_d;
  end

  // Running XOR over CH..RSV bytes; cleared whenever no payload is in flight.
  always_comb begin
    xor_d = xor_q;
    case (state_q)
      S_CH, S_OFF, S_RSV: if (sink_data_valid) xor_d = xor_q ^ sink_data;
      S_CHK:              xor_d = xor_q;
      default:            xor_d = '0;
    endcase
  end
`endif

  assign source_data_valid = valid_q;
  assign source_ch_data    = ch_out_q;
  assign source_off_data   = off_out_q;
  assign source_frame_err  = err_q;
  assign source_frame_cnt  = cnt_q;
  assign state             = state_q;

endmodule
